mcsr_file: RTL and testbench

Parametrised machine-mode CSR file for the RV32 core. It succeeds the single-timer/single-external-interrupt CSR file and adds:
- software and up to 16 platform-local interrupt lines;
- vectored trap dispatch;
- a WFI sleep state machine;
- optional 64-bit cycle/instret counters.

It sits between the decode/execute stage (Zicsr accesses, trap/return) and next-PC logic (trap target, mepc).

---
 rtl/mcsr_pkg.sv | 49 ++++
 rtl/mcsr_irq_arbiter.sv | 40 ++++
 rtl/mcsr_file.sv | 222 ++++++++++++++++++++++
 tb/tb_mcsr_file.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mcsr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, write masks,
// command encoding, interrupt cause codes and the sleep state type.
package mcsr_pkg;

  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;

  localparam logic [31:0] MIE_BASE_MASK     = 32'h0000_0888;
  localparam logic [31:0] MTVEC_MASK        = 32'hFFFF_FFFD;
  localparam logic [31:0] MEPC_MASK         = 32'hFFFF_FFFC;
  localparam logic [31:0] MCAUSE_MASK       = 32'h8000_001F;
  localparam logic [31:0] MCOUNTINH_MASK    = 32'h0000_0005;

  localparam logic [5:0] IRQ_MSI        = 6'd3;
  localparam logic [5:0] IRQ_MTI        = 6'd7;
  localparam logic [5:0] IRQ_MEI        = 6'd11;
  localparam int         IRQ_LOCAL_BASE = 16;

  typedef enum logic [1:0] {
    CSR_READ  = 2'b00,
    CSR_WRITE = 2'b01,
    CSR_SET   = 2'b10,
    CSR_CLEAR = 2'b11
  } csr_cmd_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_SLEEP = 1'b1
  } sleep_state_e;

  function automatic logic [31:0] mask_write(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

endpackage

// File: rtl/mcsr_irq_arbiter.sv
// Priority encoder for trap causes: exception first, then MEI, MSI, MTI,
// then local interrupts with the lowest index winning.
module mcsr_irq_arbiter
  import mcsr_pkg::*;
#(
  parameter int NUM_LOCAL_IRQ = 4
) (
  input  logic [31:0] pending_i,
  input  logic        exception_i,
  input  logic [5:0]  e_code_i,
  output logic [5:0]  cause_o,
  output logic        irq_o
);

  always_comb begin
    cause_o = '0;
    irq_o   = 1'b0;
    if (exception_i) begin
      cause_o = e_code_i;
    end else if (pending_i[IRQ_MEI]) begin
      cause_o = IRQ_MEI;
      irq_o   = 1'b1;
    end else if (pending_i[IRQ_MSI]) begin
      cause_o = IRQ_MSI;
      irq_o   = 1'b1;
    end else if (pending_i[IRQ_MTI]) begin
      cause_o = IRQ_MTI;
      irq_o   = 1'b1;
    end else begin
      // Scan downward so the lowest pending index is the last one assigned.
      for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--) begin
        if (pending_i[IRQ_LOCAL_BASE + i]) begin
          cause_o = 6'(IRQ_LOCAL_BASE + i);
          irq_o   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mcsr_file.sv
// Machine-mode CSR file with local interrupts, vectored traps and WFI sleep.
// Define MCSR_COUNTERS_EN to add 64-bit mcycle/minstret and mcountinhibit.
module mcsr_file
  import mcsr_pkg::*;
#(
  parameter int          NUM_LOCAL_IRQ = 4,
  parameter logic [31:0] MTVEC_RESET   = 32'h0000_0000,
  parameter logic [31:0] HART_ID       = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     csr_en,
  input  logic [1:0]               csr_cmd,
  input  logic [11:0]              csr_addr,
  input  logic [31:0]              csr_wdata,
  output logic [31:0]              csr_rdata,
  output logic                     csr_illegal,
  input  logic [31:0]              cinst_pc,
  input  logic                     exception_i,
  input  logic [5:0]               e_code,
  input  logic [31:0]              tval_i,
  input  logic                     soft_irq,
  input  logic                     timer_irq,
  input  logic                     external_irq,
  input  logic [NUM_LOCAL_IRQ-1:0] local_irq,
  input  logic                     dont_trap,
  input  logic                     trap_ret,
  input  logic                     instret_i,
  input  logic                     wfi_i,
  output logic                     trap,
  output logic [5:0]               trap_cause,
  output logic [31:0]              trap_target,
  output logic [31:0]              mepc,
  output logic                     sleep_o
);

  localparam logic [31:0] MIE_MASK =
    MIE_BASE_MASK | (((32'h1 << NUM_LOCAL_IRQ) - 32'h1) << IRQ_LOCAL_BASE);

  logic        mstatus_mie_q, mstatus_mie_d, mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  sleep_state_e state_q, state_d;

  logic [31:0] mip, pending, wval;
  logic [5:0]  arb_cause;
  logic        arb_irq, impl, read_only, wr_en;
  logic [31:0] mtvec_base;

`ifdef MCSR_COUNTERS_EN
  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic [31:0] mcountinh_q, mcountinh_d;
`else
  logic unused_instret;
  assign unused_instret = instret_i;
`endif

  always_comb begin
    mip = '0;
    mip[3]  = soft_irq;
    mip[7]  = timer_irq;
    mip[11] = external_irq;
    mip[IRQ_LOCAL_BASE +: NUM_LOCAL_IRQ] = local_irq;
  end

  assign pending = mip & mie_q;

  mcsr_irq_arbiter #(.NUM_LOCAL_IRQ(NUM_LOCAL_IRQ)) u_arbiter (
    .pending_i   (pending),
    .exception_i (exception_i),
    .e_code_i    (e_code),
    .cause_o     (arb_cause),
    .irq_o       (arb_irq)
  );

  assign trap        = (exception_i | (mstatus_mie_q & |pending)) & ~dont_trap;
  assign trap_cause  = arb_cause;
  assign mtvec_base  = {mtvec_q[31:2], 2'b00};
  // Only mode 01 vectors; the reserved 1x encodings behave as direct.
  assign trap_target = (arb_irq && mtvec_q[1:0] == 2'b01)
                       ? mtvec_base + {24'b0, arb_cause, 2'b00} : mtvec_base;
  assign mepc        = mepc_q;
  assign sleep_o     = (state_q == ST_SLEEP);

  always_comb begin
    csr_rdata = '0;
    impl      = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:  csr_rdata = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
      CSR_MIE:      csr_rdata = mie_q;
      CSR_MTVEC:    csr_rdata = mtvec_q;
      CSR_MSCRATCH: csr_rdata = mscratch_q;
      CSR_MEPC:     csr_rdata = mepc_q;
      CSR_MCAUSE:   csr_rdata = mcause_q;
      CSR_MTVAL:    csr_rdata = mtval_q;
      CSR_MIP:      csr_rdata = mip;
      CSR_MHARTID:  csr_rdata = HART_ID;
`ifdef MCSR_COUNTERS_EN
      CSR_MCOUNTINHIBIT: csr_rdata = mcountinh_q;
      CSR_MCYCLE:        csr_rdata = mcycle_q[31:0];
      CSR_MCYCLEH:       csr_rdata = mcycle_q[63:32];
      CSR_MINSTRET:      csr_rdata = minstret_q[31:0];
      CSR_MINSTRETH:     csr_rdata = minstret_q[63:32];
`endif
      default:      impl = 1'b0;
    endcase
  end

  assign read_only   = (csr_addr == CSR_MIP) || (csr_addr == CSR_MHARTID) ||
                       (csr_addr[11:10] == 2'b11);
  assign csr_illegal = csr_en && (!impl || (csr_cmd != CSR_READ && read_only));
  // A trapping instruction is squashed, so its CSR write never lands.
  assign wr_en       = csr_en && (csr_cmd != CSR_READ) && !csr_illegal && !trap;

  always_comb begin
    case (csr_cmd)
      CSR_WRITE: wval = csr_wdata;
      CSR_SET:   wval = csr_rdata | csr_wdata;
      CSR_CLEAR: wval = csr_rdata & ~csr_wdata;
      default:   wval = csr_rdata;
    endcase
  end

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (trap) begin
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
      mepc_d   = cinst_pc & ~32'h3;
      mcause_d = {arb_irq, 26'b0, arb_cause[4:0]};
      mtval_d  = arb_irq ? 32'h0 : tval_i;
    end else if (wr_en) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mstatus_mie_d  = wval[3];
          mstatus_mpie_d = wval[7];
        end
        CSR_MIE:      mie_d      = mask_write(mie_q, wval, MIE_MASK);
        CSR_MTVEC:    mtvec_d    = mask_write(mtvec_q, wval, MTVEC_MASK);
        CSR_MSCRATCH: mscratch_d = wval;
        CSR_MEPC:     mepc_d     = mask_write(mepc_q, wval, MEPC_MASK);
        CSR_MCAUSE:   mcause_d   = mask_write(mcause_q, wval, MCAUSE_MASK);
        CSR_MTVAL:    mtval_d    = wval;
        default: ;
      endcase
    end
    // mret loses only to a trap or an explicit mstatus write on the same edge.
    if (trap_ret && !trap && !(wr_en && csr_addr == CSR_MSTATUS)) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (wfi_i && !trap) state_d = ST_SLEEP;
      ST_SLEEP: if (trap || |pending) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

`ifdef MCSR_COUNTERS_EN
  always_comb begin
    mcountinh_d = mcountinh_q;
    mcycle_d    = mcycle_q;
    minstret_d  = minstret_q;
    if (wr_en && csr_addr == CSR_MCOUNTINHIBIT)
      mcountinh_d = wval & MCOUNTINH_MASK;
    if (wr_en && csr_addr == CSR_MCYCLE)       mcycle_d[31:0]  = wval;
    else if (wr_en && csr_addr == CSR_MCYCLEH) mcycle_d[63:32] = wval;
    else if (!mcountinh_q[0])                  mcycle_d = mcycle_q + 64'd1;
    if (wr_en && csr_addr == CSR_MINSTRET)       minstret_d[31:0]  = wval;
    else if (wr_en && csr_addr == CSR_MINSTRETH) minstret_d[63:32] = wval;
    else if (instret_i && !mcountinh_q[2])       minstret_d = minstret_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcountinh_q <= '0;
      mcycle_q    <= '0;
      minstret_q  <= '0;
    end else begin
      mcountinh_q <= mcountinh_d;
      mcycle_q    <= mcycle_d;
      minstret_q  <= minstret_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      state_q    <= ST_RUN;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      state_q    <= state_d;
    end
  end

endmodule

// File: tb/tb_mcsr_file.sv
// Scoreboard bench for mcsr_file: stimulus queues expected values, a monitor
// compares them against the DUT on the falling edge of each cycle.
module tb_mcsr_file;

  localparam int S_RD = 0, S_ILL = 1, S_TRAP = 2, S_CAUSE = 3;
  localparam int S_TGT = 4, S_MEPC = 5, S_SLP = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        csr_en;
  logic [1:0]  csr_cmd;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic        csr_illegal;
  logic [31:0] cinst_pc, tval_i;
  logic        exception_i;
  logic [5:0]  e_code;
  logic        soft_irq, timer_irq, external_irq;
  logic [3:0]  local_irq;
  logic        dont_trap, trap_ret, instret_i, wfi_i;
  logic        trap;
  logic [5:0]  trap_cause;
  logic [31:0] trap_target, mepc;
  logic        sleep_o;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mcsr_file #(
    .NUM_LOCAL_IRQ (4),
    .MTVEC_RESET   (32'h0000_0100),
    .HART_ID       (32'h0000_0005)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .csr_en       (csr_en),
    .csr_cmd      (csr_cmd),
    .csr_addr     (csr_addr),
    .csr_wdata    (csr_wdata),
    .csr_rdata    (csr_rdata),
    .csr_illegal  (csr_illegal),
    .cinst_pc     (cinst_pc),
    .exception_i  (exception_i),
    .e_code       (e_code),
    .tval_i       (tval_i),
    .soft_irq     (soft_irq),
    .timer_irq    (timer_irq),
    .external_irq (external_irq),
    .local_irq    (local_irq),
    .dont_trap    (dont_trap),
    .trap_ret     (trap_ret),
    .instret_i    (instret_i),
    .wfi_i        (wfi_i),
    .trap         (trap),
    .trap_cause   (trap_cause),
    .trap_target  (trap_target),
    .mepc         (mepc),
    .sleep_o      (sleep_o)
  );

  // Monitor: drains every expectation queued for the current cycle.
  exp_t        mon_e;
  logic [31:0] mon_act;
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      case (mon_e.sel)
        S_RD:    mon_act = csr_rdata;
        S_ILL:   mon_act = {31'b0, csr_illegal};
        S_TRAP:  mon_act = {31'b0, trap};
        S_CAUSE: mon_act = {26'b0, trap_cause};
        S_TGT:   mon_act = trap_target;
        S_MEPC:  mon_act = mepc;
        default: mon_act = {31'b0, sleep_o};
      endcase
      checks++;
      if (mon_act !== mon_e.val) begin
        errors++;
        $display("FAIL %s: got %h expected %h", mon_e.name, mon_act, mon_e.val);
      end else begin
        $display("check %s: %h", mon_e.name, mon_act);
      end
    end
  end

  task automatic expect_v(input string n, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.sel  = sel;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    csr_en = 1'b0; csr_cmd = 2'b00; csr_addr = '0; csr_wdata = '0;
    cinst_pc = '0; exception_i = 1'b0; e_code = '0; tval_i = '0;
    soft_irq = 1'b0; timer_irq = 1'b0; external_irq = 1'b0; local_irq = '0;
    dont_trap = 1'b0; trap_ret = 1'b0; instret_i = 1'b0; wfi_i = 1'b0;
  endtask

  task automatic csr(input logic [1:0] cmd, input logic [11:0] addr, input logic [31:0] wd);
    csr_en = 1'b1; csr_cmd = cmd; csr_addr = addr; csr_wdata = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    csr(2'b00, 12'h305, 0);
    expect_v("reset_mtvec", S_RD, 32'h100);
    expect_v("reset_ill", S_ILL, 0);
    expect_v("reset_trap", S_TRAP, 0);
    expect_v("reset_sleep", S_SLP, 0);
    expect_v("reset_mepc", S_MEPC, 0);
    next_cycle(); csr(2'b00, 12'h300, 0);          expect_v("mstatus_mpp", S_RD, 32'h1800);
    next_cycle(); csr(2'b00, 12'hF14, 0);          expect_v("mhartid", S_RD, 32'h5);
    next_cycle(); csr(2'b01, 12'h305, 32'h201);    expect_v("mtvec_old", S_RD, 32'h100);
    next_cycle(); csr(2'b01, 12'h304, 32'h80);     expect_v("mie_old", S_RD, 32'h0);
    next_cycle(); csr(2'b10, 12'h300, 32'h8);      expect_v("mstatus_rmw_old", S_RD, 32'h1800);
    next_cycle(); csr(2'b00, 12'h300, 0);          expect_v("mstatus_mie_set", S_RD, 32'h1808);
    // Vectored timer interrupt
    next_cycle(); timer_irq = 1'b1; cinst_pc = 32'h42;
    expect_v("mti_trap", S_TRAP, 1);
    expect_v("mti_cause", S_CAUSE, 7);
    expect_v("mti_target", S_TGT, 32'h21C);
    next_cycle(); timer_irq = 1'b1; csr(2'b00, 12'h342, 0);
    expect_v("mti_mcause", S_RD, 32'h8000_0007);
    expect_v("mti_mepc", S_MEPC, 32'h40);
    expect_v("mie_cleared_no_trap", S_TRAP, 0);
    next_cycle(); csr(2'b00, 12'h300, 0);          expect_v("mstatus_after_trap", S_RD, 32'h1880);
    next_cycle(); trap_ret = 1'b1; csr(2'b00, 12'h300, 0);
    expect_v("mstatus_during_mret", S_RD, 32'h1880);
    next_cycle(); csr(2'b00, 12'h300, 0);          expect_v("mstatus_after_mret", S_RD, 32'h1888);
    next_cycle(); csr(2'b10, 12'h304, 32'h50808);  expect_v("mie_set_old", S_RD, 32'h80);
    next_cycle(); csr(2'b00, 12'h304, 0);          expect_v("mie_value", S_RD, 32'h50888);
    // Priority with the trap blocked by dont_trap
    next_cycle(); dont_trap = 1; external_irq = 1; timer_irq = 1; soft_irq = 1; local_irq = 4'b0001;
    csr(2'b00, 12'h344, 0);
    expect_v("mip_value", S_RD, 32'h10888);
    expect_v("dont_trap", S_TRAP, 0);
    expect_v("prio_mei", S_CAUSE, 11);
    next_cycle(); dont_trap = 1; timer_irq = 1; soft_irq = 1; local_irq = 4'b0001;
    expect_v("prio_msi", S_CAUSE, 3);
    next_cycle(); dont_trap = 1; timer_irq = 1; local_irq = 4'b0001;
    expect_v("prio_mti", S_CAUSE, 7);
    next_cycle(); dont_trap = 1; local_irq = 4'b0101;
    expect_v("prio_local", S_CAUSE, 16);
    // Exception beats every interrupt and uses the base address
    next_cycle(); external_irq = 1; timer_irq = 1; local_irq = 4'b0001;
    exception_i = 1; e_code = 6'd2; tval_i = 32'h1234; cinst_pc = 32'h80;
    expect_v("exc_trap", S_TRAP, 1);
    expect_v("exc_cause", S_CAUSE, 2);
    expect_v("exc_target", S_TGT, 32'h200);
    next_cycle(); csr(2'b00, 12'h343, 0);
    expect_v("exc_mtval", S_RD, 32'h1234);
    expect_v("exc_mepc", S_MEPC, 32'h80);
    next_cycle(); csr(2'b00, 12'h342, 0);          expect_v("exc_mcause", S_RD, 32'h2);
    next_cycle(); exception_i = 1; e_code = 6'd2; csr(2'b01, 12'h340, 32'hDEAD_BEEF);
    expect_v("squash_trap", S_TRAP, 1);
    next_cycle(); csr(2'b00, 12'h340, 0);          expect_v("mscratch_squashed", S_RD, 32'h0);
    next_cycle(); csr(2'b01, 12'h340, 32'hCAFE_F00D); expect_v("mscratch_wr_ill", S_ILL, 0);
    next_cycle(); csr(2'b00, 12'h340, 0);          expect_v("mscratch_value", S_RD, 32'hCAFE_F00D);
    next_cycle(); csr(2'b01, 12'hF14, 32'h1);      expect_v("mhartid_write_ill", S_ILL, 1);
    next_cycle(); csr(2'b10, 12'h344, 32'h1);      expect_v("mip_set_ill", S_ILL, 1);
    next_cycle(); csr(2'b00, 12'h7C0, 0);
    expect_v("unimpl_ill", S_ILL, 1);
    expect_v("unimpl_rdata", S_RD, 0);
    next_cycle(); csr(2'b00, 12'hF14, 0);          expect_v("mhartid_kept", S_RD, 32'h5);
    next_cycle(); csr(2'b11, 12'h305, 32'h1);      expect_v("mtvec_clear_old", S_RD, 32'h201);
    next_cycle(); csr(2'b00, 12'h305, 0);          expect_v("mtvec_cleared", S_RD, 32'h200);
    // WFI sleep with MIE = 0, woken by local_irq[2]
    next_cycle(); wfi_i = 1;                       expect_v("wfi_cycle_sleep", S_SLP, 0);
    next_cycle();                                  expect_v("sleeping", S_SLP, 1);
    next_cycle();                                  expect_v("still_sleeping", S_SLP, 1);
    next_cycle(); local_irq = 4'b0100;
    expect_v("wake_cycle_sleep", S_SLP, 1);
    expect_v("wake_cycle_trap", S_TRAP, 0);
    next_cycle(); local_irq = 4'b0100;
    expect_v("awake", S_SLP, 0);
    expect_v("awake_trap", S_TRAP, 0);
`ifdef MCSR_COUNTERS_EN
    next_cycle(); csr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    next_cycle(); csr(2'b01, 12'hB80, 32'h0);
    next_cycle(); csr(2'b00, 12'hB00, 0);          expect_v("mcycle_lo_written", S_RD, 32'hFFFF_FFFF);
    next_cycle(); csr(2'b00, 12'hB80, 0);          expect_v("mcycle_carry", S_RD, 32'h1);
    next_cycle(); csr(2'b10, 12'h320, 32'h1);
    next_cycle(); csr(2'b00, 12'hB00, 0);          expect_v("mcycle_inhibit", S_RD, 32'h2);
    next_cycle(); csr(2'b00, 12'hB00, 0);          expect_v("mcycle_frozen", S_RD, 32'h2);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); instret_i = 1;
    end
    next_cycle(); csr(2'b00, 12'hB02, 0);          expect_v("minstret", S_RD, 32'h3);
`else
    next_cycle(); csr(2'b00, 12'hB00, 0);
    expect_v("mcycle_absent_ill", S_ILL, 1);
    expect_v("mcycle_absent_rd", S_RD, 0);
`endif
    next_cycle();
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
